// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: datapath widths and writeback source selects.
package riscv_pipe_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned REG_ADDR_W = $clog2(NUM_REGS);
  localparam int unsigned CNT_W      = 64;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_MEM  = 2'd1;
  localparam logic [1:0] WB_SEL_PC   = 2'd2;
  localparam logic [1:0] WB_SEL_RSVD = 2'd3;

endpackage

// File: rtl/retire_counter.sv
// Retired-instruction counter with independent low/high half CSR loads.
module retire_counter #(
  parameter int unsigned CNT_W  = 64,
  parameter int unsigned HALF_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_inc,
  input  logic [1:0]        i_wr,
  input  logic [HALF_W-1:0] i_wr_data,
  output logic [CNT_W-1:0]  o_count
);

  logic [CNT_W-1:0] r_count;

  // A CSR write takes priority; a retirement in the same cycle is not counted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_wr != 2'b00) begin
      if (i_wr[0]) r_count[HALF_W-1:0]     <= i_wr_data;
      if (i_wr[1]) r_count[CNT_W-1:HALF_W] <= (CNT_W-HALF_W)'(i_wr_data);
    end else if (i_inc) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/wb_stage_regfile.sv
// Writeback stage: writeback mux, integer register file with two async read ports, retire counter.
// Optional same-cycle WB->read bypass enabled by defining RF_BYPASS_EN.
module wb_stage_regfile
  import riscv_pipe_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_retired_i,
  input  logic                  rf_en_i,
  input  logic [1:0]            wb_sel_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic [XLEN-1:0]       alu_res_i,
  input  logic [XLEN-1:0]       read_data_i,
  input  logic [XLEN-1:0]       next_seq_pc_i,
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  output logic [XLEN-1:0]       rs1_data_o,
  output logic [XLEN-1:0]       rs2_data_o,
  output logic                  wb_en_o,
  output logic [REG_ADDR_W-1:0] wb_rd_o,
  output logic [XLEN-1:0]       wb_data_o,
  input  logic [1:0]            instret_wr_i,
  input  logic [XLEN-1:0]       instret_wr_data_i,
  output logic [CNT_W-1:0]      instret_o
);

  logic [XLEN-1:0] r_regs [NUM_REGS];
  logic [XLEN-1:0] w_wb_data;
  logic            w_wb_en;
  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;

  // Writeback source select; the reserved encoding yields zero.
  always_comb begin
    w_wb_data = '0;
    case (wb_sel_i)
      WB_SEL_ALU:  w_wb_data = alu_res_i;
      WB_SEL_MEM:  w_wb_data = read_data_i;
      WB_SEL_PC:   w_wb_data = next_seq_pc_i;
      WB_SEL_RSVD: w_wb_data = '0;
      default:     w_wb_data = '0;
    endcase
  end

  assign w_wb_en   = instr_retired_i & rf_en_i & (rd_i != '0);
  assign wb_en_o   = w_wb_en;
  assign wb_rd_o   = rd_i;
  assign wb_data_o = w_wb_data;

  // Entry 0 is never written; reads of index 0 are forced to zero below.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wb_en) begin
      r_regs[rd_i] <= w_wb_data;
    end
  end

  always_comb begin
    w_rs1_data = r_regs[rs1_addr_i];
    w_rs2_data = r_regs[rs2_addr_i];
`ifdef RF_BYPASS_EN
    if (w_wb_en && (rd_i == rs1_addr_i)) w_rs1_data = w_wb_data;
    if (w_wb_en && (rd_i == rs2_addr_i)) w_rs2_data = w_wb_data;
`endif
    if (rs1_addr_i == '0) w_rs1_data = '0;
    if (rs2_addr_i == '0) w_rs2_data = '0;
  end

  assign rs1_data_o = w_rs1_data;
  assign rs2_data_o = w_rs2_data;

  retire_counter #(
    .CNT_W  (CNT_W),
    .HALF_W (XLEN)
  ) u_retire_counter (
    .clk       (clk),
    .reset     (reset),
    .i_inc     (instr_retired_i),
    .i_wr      (instret_wr_i),
    .i_wr_data (instret_wr_data_i),
    .o_count   (instret_o)
  );

endmodule

// File: tb/tb_wb_stage_regfile.sv
// Randomized self-checking bench for wb_stage_regfile against an array/counter reference model.
module tb_wb_stage_regfile;
  import riscv_pipe_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  instr_retired_i;
  logic                  rf_en_i;
  logic [1:0]            wb_sel_i;
  logic [REG_ADDR_W-1:0] rd_i;
  logic [XLEN-1:0]       alu_res_i;
  logic [XLEN-1:0]       read_data_i;
  logic [XLEN-1:0]       next_seq_pc_i;
  logic [REG_ADDR_W-1:0] rs1_addr_i;
  logic [REG_ADDR_W-1:0] rs2_addr_i;
  logic [XLEN-1:0]       rs1_data_o;
  logic [XLEN-1:0]       rs2_data_o;
  logic                  wb_en_o;
  logic [REG_ADDR_W-1:0] wb_rd_o;
  logic [XLEN-1:0]       wb_data_o;
  logic [1:0]            instret_wr_i;
  logic [XLEN-1:0]       instret_wr_data_i;
  logic [CNT_W-1:0]      instret_o;

  always #5 clk = ~clk;

  wb_stage_regfile dut (
    .clk               (clk),
    .reset             (reset),
    .instr_retired_i   (instr_retired_i),
    .rf_en_i           (rf_en_i),
    .wb_sel_i          (wb_sel_i),
    .rd_i              (rd_i),
    .alu_res_i         (alu_res_i),
    .read_data_i       (read_data_i),
    .next_seq_pc_i     (next_seq_pc_i),
    .rs1_addr_i        (rs1_addr_i),
    .rs2_addr_i        (rs2_addr_i),
    .rs1_data_o        (rs1_data_o),
    .rs2_data_o        (rs2_data_o),
    .wb_en_o           (wb_en_o),
    .wb_rd_o           (wb_rd_o),
    .wb_data_o         (wb_data_o),
    .instret_wr_i      (instret_wr_i),
    .instret_wr_data_i (instret_wr_data_i),
    .instret_o         (instret_o)
  );

  // Reference model state
  logic [31:0] m_rf [32];
  logic [63:0] m_cnt;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_wb_data();
    case (wb_sel_i)
      2'd0:    return alu_res_i;
      2'd1:    return read_data_i;
      2'd2:    return next_seq_pc_i;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_wb_en();
    return instr_retired_i && rf_en_i && (rd_i != 5'd0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef RF_BYPASS_EN
    if (m_wb_en() && rd_i == a) return m_wb_data();
`endif
    return m_rf[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_cnt = 64'd0;
  endtask

  task automatic idle();
    instr_retired_i   = 1'b0;
    rf_en_i           = 1'b0;
    wb_sel_i          = 2'd0;
    rd_i              = 5'd0;
    alu_res_i         = 32'd0;
    read_data_i       = 32'd0;
    next_seq_pc_i     = 32'd0;
    instret_wr_i      = 2'b00;
    instret_wr_data_i = 32'd0;
  endtask

  task automatic drive_wb(input logic ret, input logic en, input logic [1:0] sel,
                          input logic [4:0] rd, input logic [31:0] val);
    idle();
    instr_retired_i = ret;
    rf_en_i         = en;
    wb_sel_i        = sel;
    rd_i            = rd;
    alu_res_i       = val;
    read_data_i     = ~val;
    next_seq_pc_i   = val ^ 32'h0F0F_0F0F;
  endtask

  // Check combinational outputs mid-cycle, then advance the model on the edge.
  task automatic step();
    @(negedge clk);
    check("wb_data", 64'(wb_data_o), 64'(m_wb_data()));
    check("wb_en", 64'(wb_en_o), 64'(m_wb_en()));
    check("wb_rd", 64'(wb_rd_o), 64'(rd_i));
    check("rs1", 64'(rs1_data_o), 64'(m_read(rs1_addr_i)));
    check("rs2", 64'(rs2_data_o), 64'(m_read(rs2_addr_i)));
    check("instret", instret_o, m_cnt);
    @(posedge clk);
    if (m_wb_en()) m_rf[rd_i] = m_wb_data();
    if (instret_wr_i != 2'b00) begin
      if (instret_wr_i[0]) m_cnt[31:0]  = instret_wr_data_i;
      if (instret_wr_i[1]) m_cnt[63:32] = instret_wr_data_i;
    end else if (instr_retired_i) begin
      m_cnt = m_cnt + 64'd1;
    end
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      rs1_addr_i = 5'(i);
      rs2_addr_i = 5'(31 - i);
      #1;
      if (rs1_data_o !== 32'd0 || rs2_data_o !== 32'd0)
        check(tag, 64'({rs1_data_o, rs2_data_o}), 64'd0);
    end
    check(tag, 64'(rs1_data_o | rs2_data_o), 64'd0);
    check({tag, "_instret"}, instret_o, 64'd0);
  endtask

  initial begin
    idle();
    rs1_addr_i = 5'd0;
    rs2_addr_i = 5'd0;
    reset = 1'b0;
    model_reset();
    #12;
    check_all_zero("reset_init");
    @(negedge clk) reset = 1'b1;
    @(posedge clk) #1;

    // ALU write then read back
    drive_wb(1'b1, 1'b1, WB_SEL_ALU, 5'd5, 32'hDEADBEEF);
    rs1_addr_i = 5'd5;
    step();
    idle();
    step();
    check("alu_x5", 64'(rs1_data_o), 64'h0000_0000_DEAD_BEEF);

    // x0 never written, bubble never writes
    drive_wb(1'b1, 1'b1, WB_SEL_ALU, 5'd7, 32'h0000_7777);
    step();
    drive_wb(1'b1, 1'b1, WB_SEL_ALU, 5'd0, 32'h0000_1234);
    step();
    drive_wb(1'b0, 1'b1, WB_SEL_ALU, 5'd7, 32'h0000_AAAA);
    check("bubble_en", 64'(wb_en_o), 64'd0);
    step();
    idle();
    rs1_addr_i = 5'd0;
    rs2_addr_i = 5'd7;
    step();
    check("x0_zero", 64'(rs1_data_o), 64'd0);
    check("x7_held", 64'(rs2_data_o), 64'h7777);

    // Link value and reserved select
    idle();
    instr_retired_i = 1'b1; rf_en_i = 1'b1; wb_sel_i = WB_SEL_PC; rd_i = 5'd1;
    next_seq_pc_i = 32'h8000_0004; alu_res_i = 32'h1111_1111;
    step();
    idle();
    wb_sel_i = WB_SEL_RSVD; alu_res_i = 32'hFFFF_FFFF; read_data_i = 32'hFFFF_FFFF;
    next_seq_pc_i = 32'hFFFF_FFFF; rs1_addr_i = 5'd1;
    step();
    check("rsvd_zero", 64'(wb_data_o), 64'd0);
    check("link_x1", 64'(rs1_data_o), 64'h8000_0004);

    // Same-cycle write/read of x9
    drive_wb(1'b1, 1'b1, WB_SEL_ALU, 5'd9, 32'h0000_0055);
    rs2_addr_i = 5'd9;
    #1;
`ifdef RF_BYPASS_EN
    check("bypass_same", 64'(rs2_data_o), 64'h55);
`else
    check("bypass_same", 64'(rs2_data_o), 64'h0);
`endif
    step();
    idle();
    step();
    check("bypass_next", 64'(rs2_data_o), 64'h55);

    // Counter wrap and half-word CSR load
    idle();
    instret_wr_i = 2'b11; instret_wr_data_i = 32'hFFFF_FFFF; instr_retired_i = 1'b1;
    step();
    check("cnt_preload", instret_o, 64'hFFFF_FFFF_FFFF_FFFF);
    idle();
    instr_retired_i = 1'b1;
    step();
    check("cnt_wrap", instret_o, 64'd0);
    instret_wr_i = 2'b11; instret_wr_data_i = 32'h0000_0123; instr_retired_i = 1'b0;
    step();
    instret_wr_i = 2'b01; instret_wr_data_i = 32'd7; instr_retired_i = 1'b1;
    step();
    check("cnt_lo_load", instret_o, 64'h0000_0123_0000_0007);
    idle();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      instr_retired_i   = 1'($urandom);
      rf_en_i           = 1'($urandom);
      wb_sel_i          = 2'($urandom);
      rd_i              = 5'($urandom);
      alu_res_i         = $urandom;
      read_data_i       = $urandom;
      next_seq_pc_i     = $urandom;
      rs1_addr_i        = ($urandom_range(0, 3) == 0) ? rd_i : 5'($urandom);
      rs2_addr_i        = ($urandom_range(0, 3) == 0) ? rd_i : 5'($urandom);
      instret_wr_i      = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00;
      instret_wr_data_i = $urandom;
      if (n == 200) begin
        // Reset asserted mid-write: the edge inside reset must not commit anything
        instr_retired_i = 1'b1; rf_en_i = 1'b1; rd_i = 5'd3;
        #2 reset = 1'b0;
        @(posedge clk) #1;
        check_all_zero("reset_mid");
        model_reset();
        idle();
        @(negedge clk) reset = 1'b1;
        @(posedge clk) #1;
      end else begin
        step();
      end
    end

    // Final sweep of every register through both ports
    idle();
    for (int i = 0; i < 32; i++) begin
      rs1_addr_i = 5'(i);
      rs2_addr_i = 5'(31 - i);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
